// File: rtl/microtile_alu.sv
// microtile_alu: handshaked W-bit ALU with add, saturating accumulate,
// LSB-first shift-and-add multiply and accumulator clear; one registered result per op.
module microtile_alu #(
  parameter int W     = 4,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [W-1:0]     op_a,
  input  logic [W-1:0]     op_b,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] result,
  output logic             out_valid,
  output logic             ovf
);

  localparam int                CNT_W = (W > 1) ? $clog2(W) : 1;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(W - 1);
  localparam logic [OUT_W-1:0]  SAT   = '1;

  typedef enum logic [1:0] {
    MODE_ADD = 2'b00,
    MODE_ACC = 2'b01,
    MODE_MUL = 2'b10,
    MODE_CLR = 2'b11
  } mode_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

  generate
    if (W < 1 || OUT_W < 2 * W) begin : g_bad_params
      $error("microtile_alu: need W >= 1 and OUT_W >= 2*W");
    end
  endgenerate

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [OUT_W-1:0] acc_q;
  logic [OUT_W-1:0] result_q;
  logic             ovf_q;
  logic             out_valid_q;

  logic [OUT_W-1:0] mcand_q;
  logic [W-1:0]     mplier_q;
  logic [OUT_W-1:0] prod_q;

  mode_e            op_mode;
  logic [OUT_W:0]   acc_sum_d;
  logic [OUT_W-1:0] prod_d;

  always_comb begin
    op_mode   = mode_e'(mode);
    // One extra bit so the carry out of the accumulator marks saturation.
    acc_sum_d = {1'b0, acc_q} + (OUT_W+1)'(op_a) + (OUT_W+1)'(op_b);
    prod_d    = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
  end

  // Control and result registers; reset wins over enable, accept and completion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (ena) begin
      out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            case (op_mode)
              MODE_ADD: begin
                result_q    <= OUT_W'(op_a) + OUT_W'(op_b);
                ovf_q       <= 1'b0;
                out_valid_q <= 1'b1;
              end
              MODE_ACC: begin
                if (acc_sum_d[OUT_W]) begin
                  acc_q    <= SAT;
                  result_q <= SAT;
                  ovf_q    <= 1'b1;
                end else begin
                  acc_q    <= acc_sum_d[OUT_W-1:0];
                  result_q <= acc_sum_d[OUT_W-1:0];
                  ovf_q    <= 1'b0;
                end
                out_valid_q <= 1'b1;
              end
              MODE_MUL: begin
                state_q <= S_MUL;
                cnt_q   <= '0;
              end
              MODE_CLR: begin
                acc_q       <= '0;
                result_q    <= '0;
                ovf_q       <= 1'b0;
                out_valid_q <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        S_MUL: begin
          if (cnt_q == LAST) begin
            result_q    <= prod_d;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // NOTE: the multiply datapath has no reset; it is reloaded on every idle cycle
  // and only observed through result_q once the FSM has stepped it W times.
  always_ff @(posedge clk) begin
    if (ena) begin
      if (state_q == S_IDLE) begin
        mcand_q  <= OUT_W'(op_a);
        mplier_q <= op_b;
        prod_q   <= '0;
      end else begin
        prod_q   <= prod_d;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
      end
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign result    = result_q;
  assign out_valid = out_valid_q;
  assign ovf       = ovf_q;

endmodule

// File: doc/microtile_alu.md
# microtile_alu

Parametrised, handshaked successor to the microtile registered nibble adder. It takes two W-bit operands and a 2-bit mode. It produces one registered OUT_W-bit result per accepted operation. Modes are plain add, saturating accumulate, sequential shift-and-add multiply, and accumulator clear. It sits directly behind the tile's dedicated inputs and drives the dedicated outputs.

## Interface
Parameters:
- W, default 4: operand width; must be ≥ 1.
- OUT_W, default 8: result/accumulator width; must be ≥ 2*W (elaboration-time check).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- ena  in  1  clock enable; when low, all state, including out_valid, holds.
- op_a  in  W  operand A (unsigned).
- op_b  in  W  operand B (unsigned).
- mode  in  2  00 ADD, 01 ACC, 10 MUL, 11 CLR.
- in_valid  in  1  request present.
- in_ready  out  1  high when state is IDLE; combinational from state.
- result  out  OUT_W  registered result; holds until the next completion.
- out_valid  out  1  high for exactly one enabled cycle per completed operation.
- ovf  out  1  saturation flag; updated together with result.

## Operation
- An operation is accepted on an enabled edge where in_valid & in_ready.
- While busy, in_valid is ignored: no queueing, no error.
- State machine:
  - IDLE: accept.
    - ADD, ACC or CLR stays in IDLE.
    - MUL goes to MUL with iteration count 0.
  - MUL: one partial-product step per enabled edge.
    - After W steps: register the product, pulse out_valid, return to IDLE.
- ADD: result = zero-extend(op_a) + zero-extend(op_b); ovf = 0. The accumulator is untouched.
- ACC:
  - Form sum = acc + op_a + op_b in OUT_W+1 bits.
  - If sum > 2^OUT_W−1: acc = 2^OUT_W−1 and ovf = 1. Otherwise acc = sum and ovf = 0.
  - result = new acc. Once saturated, acc stays saturated until CLR.
- MUL:
  - Operands are latched at accept; later changes on op_a/op_b have no effect.
  - LSB-first shift-and-add over W iterations. result = op_a*op_b (exact, ≤ 2W bits, zero-extended); ovf = 0.
  - The accumulator is untouched.
- CLR: acc = 0, result = 0, ovf = 0, out_valid pulses.
- out_valid is deasserted on the next enabled edge after it was raised, unless another completion occurs on that edge.

## Timing
- Request accepted at enabled edge k:
  - ADD/ACC/CLR: result, ovf and out_valid are visible after edge k+1 (latency 1, throughput 1 per cycle).
  - MUL: iterations run on enabled edges k+1..k+W. Result and out_valid are visible after edge k+W.
  - MUL: in_ready is low from after edge k until after edge k+W. A new request can be accepted on edge k+W+1 at the earliest.
- ena low stretches latency by the number of disabled cycles. No state, iteration count or flag changes.
- Reset, at any rising edge with rst_n = 0, regardless of ena:
  - state = IDLE, acc = 0, result = 0, ovf = 0, out_valid = 0.
  - in_ready = 1 on the cycle after.
- Reset mid-MUL aborts the operation; no out_valid is produced.
- Reset has priority over accept and completion on the same edge.

## Test plan
(W = 4, OUT_W = 8 unless noted.)
- Reset: rst_n low 2 cycles with random inputs → result 0, ovf 0, out_valid 0; in_ready 1 after release.
- ADD a=15, b=15 → 30 one cycle later, one-cycle out_valid, ovf 0. Back-to-back ADD every cycle (1+2, 3+4, 5+6) → out_valid continuously high; results 3, 7, 11 each one cycle behind.
- CLR, then ACC (15,15) issued 10 times → results 30, 60, …, 240 with ovf 0. The 9th gives 255 with ovf 1; the 10th stays 255 with ovf 1. A following CLR gives 0 with ovf 0.
- MUL 13×11 → result 143 (0x8F) exactly 4 cycles after accept, and in_ready low for those 4 cycles. An ADD request presented while busy is ignored and produces no extra out_valid. Also MUL 15×15 → 225, MUL 0×9 → 0.
- ena low for 3 cycles in the middle of MUL 13×11 → out_valid arrives 7 cycles after accept, result 143. ena low while out_valid is high → out_valid stays high until the next enabled edge.
- rst_n low at MUL iteration 2 → no out_valid, result 0, in_ready 1. A new ADD 2+3 afterwards → 5.
- Parameter sweep W=1/OUT_W=2 and W=8/OUT_W=16: 255×255 → 65025 after 8 cycles; ACC saturates at 65535.
